// File: rtl/li_expander.sv
// rtl/li_expander.sv - sequential immediate encoder emitting MIPS load/jump sequences
//
// Purpose: turns a 32-bit constant or jump target plus destination register
// into the shortest instruction sequence (ori / addiu / lui / lui+ori / j) that
// rebuilds it, each word tagged with the extender control code it relies on.
//
// Ports:
//   clk, reset_n               clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake
//   req_kind                   0 = load constant, 1 = jump to target
//   req_rt                     destination register (load only)
//   req_value                  constant or byte jump target
//   instr_valid/instr_ready    instruction stream handshake
//   instr, instr_last          encoded word, final word of the request
//   enc_ctrl                   0 zero, 1 sign, 2 upper, 3 jump
//   err                        one-cycle pulse: request rejected
module li_expander (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_kind,
  input  logic [4:0]  req_rt,
  input  logic [31:0] req_value,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        instr_last,
  output logic [1:0]  enc_ctrl,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT1 = 2'd1,
    S_EMIT2 = 2'd2
  } state_t;

  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  state_t      r_state;
  logic        r_kind;
  logic [4:0]  r_rt;
  logic [31:0] r_value;
  logic        r_err;

  logic        w_accept;
  logic        w_jump_ok;
  logic        w_req_bad;
  logic        w_out_hs;
  logic [15:0] w_lo;
  logic [15:0] w_hi;
  logic [31:0] w_word1;
  logic [31:0] w_word2;
  logic [1:0]  w_enc1;
  logic        w_two;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  // The extender rebuilds a jump target as {4'h0, imm26, 2'h0}; anything it
  // cannot reproduce is rejected up front so the FSM never leaves IDLE.
  assign w_jump_ok = (req_value[31:28] == 4'h0) && (req_value[1:0] == 2'b00);
  assign w_req_bad = req_kind && !w_jump_ok;
  assign w_out_hs  = instr_valid && instr_ready;

  assign w_lo = r_value[15:0];
  assign w_hi = r_value[31:16];

  // Encoding selection from the captured request; first matching rule wins.
  always_comb begin
    w_word1 = 32'h0;
    w_enc1  = 2'd0;
    w_two   = 1'b0;
    if (r_kind) begin
      w_word1 = {OP_J, r_value[27:2]};
      w_enc1  = 2'd3;
    end else if (w_hi == 16'h0) begin
      w_word1 = {OP_ORI, 5'd0, r_rt, w_lo};
      w_enc1  = 2'd0;
    end else if (&r_value[31:15]) begin
      w_word1 = {OP_ADDIU, 5'd0, r_rt, w_lo};
      w_enc1  = 2'd1;
    end else if (w_lo == 16'h0) begin
      w_word1 = {OP_LUI, 5'd0, r_rt, w_hi};
      w_enc1  = 2'd2;
    end else begin
      w_word1 = {OP_LUI, 5'd0, r_rt, w_hi};
      w_enc1  = 2'd2;
      w_two   = 1'b1;
    end
  end

  // Second word ORs the low half into the register the lui just loaded.
  assign w_word2 = {OP_ORI, r_rt, r_rt, w_lo};

  // Outputs depend only on registered state, so there is no path from req_*
  // or instr_ready into instr*. Captured registers are frozen outside IDLE,
  // which keeps the word stable under backpressure.
  assign req_ready   = (r_state == S_IDLE);
  assign instr_valid = (r_state != S_IDLE);
  assign instr       = (r_state == S_EMIT1) ? w_word1 :
                       (r_state == S_EMIT2) ? w_word2 : 32'h0;
  assign instr_last  = ((r_state == S_EMIT1) && !w_two) || (r_state == S_EMIT2);
  assign enc_ctrl    = (r_state == S_EMIT1) ? w_enc1 : 2'd0;
  assign err         = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_kind  <= 1'b0;
      r_rt    <= 5'd0;
      r_value <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_req_bad;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_kind  <= req_kind;
            r_rt    <= req_rt;
            r_value <= req_value;
            if (!w_req_bad) begin
              r_state <= S_EMIT1;
            end
          end
        end
        S_EMIT1: begin
          if (w_out_hs) begin
            r_state <= w_two ? S_EMIT2 : S_IDLE;
          end
        end
        S_EMIT2: begin
          if (w_out_hs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_li_expander.sv
// tb/tb_li_expander.sv - scoreboard bench for li_expander
module tb_li_expander;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_kind;
  logic [4:0]  req_rt;
  logic [31:0] req_value;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_last;
  logic [1:0]  enc_ctrl;
  logic        err;

  li_expander dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_rt      (req_rt),
    .req_value   (req_value),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_last  (instr_last),
    .enc_ctrl    (enc_ctrl),
    .err         (err)
  );

  int          total;
  int          bad;
  int          err_seen;
  int          err_exp;
  int          hs_cnt;
  int          rdy_mode;
  logic        rdy_force;
  logic        prev_stall;
  logic [34:0] prev_word;
  logic [34:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: entries are {instr, last, enc_ctrl}; returns word count (0 = rejected).
  function automatic int model(input bit kind, input logic [4:0] rt, input logic [31:0] v,
                               output logic [34:0] w0, output logic [34:0] w1);
    logic [31:0] lo, hi, r;
    lo = v % 32'h10000;
    hi = v / 32'h10000;
    r  = 32'(rt);
    w0 = '0;
    w1 = '0;
    if (kind) begin
      if (v < 32'h10000000 && (v % 4) == 0) begin
        w0 = {(32'h02 << 26) | (v >> 2), 1'b1, 2'd3};
        return 1;
      end
      return 0;
    end
    if (hi == 0) begin
      w0 = {(32'h0D << 26) | (r << 16) | lo, 1'b1, 2'd0};
      return 1;
    end
    if (v >= 32'hFFFF8000) begin
      w0 = {(32'h09 << 26) | (r << 16) | lo, 1'b1, 2'd1};
      return 1;
    end
    if (lo == 0) begin
      w0 = {(32'h0F << 26) | (r << 16) | hi, 1'b1, 2'd2};
      return 1;
    end
    w0 = {(32'h0F << 26) | (r << 16) | hi, 1'b0, 2'd2};
    w1 = {(32'h0D << 26) | (r << 21) | (r << 16) | lo, 1'b1, 2'd0};
    return 2;
  endfunction

  task automatic push(input logic [31:0] w, input logic last, input logic [1:0] e);
    exp_q.push_back({w, last, e});
  endtask

  // Called at posedge+1; returns at posedge+1 so consecutive calls are back-to-back.
  task automatic send(input bit kind, input logic [4:0] rt, input logic [31:0] v,
                      input bit use_model, output time acc_t);
    logic [34:0] w0, w1;
    int n;
    bit got;
    n = model(kind, rt, v, w0, w1);
    if (use_model) begin
      if (n >= 1) exp_q.push_back(w0);
      if (n == 2) exp_q.push_back(w1);
    end
    if (n == 0) err_exp++;
    req_valid = 1'b1;
    req_kind  = kind;
    req_rt    = rt;
    req_value = v;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) begin
      chk("req_accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      acc_t = 0;
      return;
    end
    @(posedge clk);
    acc_t = $time;
    #1 req_valid = 1'b0;
    if (n > 0) begin
      @(negedge clk);
      chk("first_word_latency", 64'(instr_valid), 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // instr_ready driver: random or forced, applied 2 units after each edge.
  initial begin
    instr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      instr_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks hold and err.
  initial begin
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall)
        chk("hold_stable", 64'({instr_valid, instr, instr_last, enc_ctrl}), 64'({1'b1, prev_word}));
      if (err) err_seen++;
      if (instr_valid) begin
        if (instr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'({instr, instr_last, enc_ctrl}), 64'h7FFFFFFFF);
          end else begin
            chk("word", 64'({instr, instr_last, enc_ctrl}), 64'(exp_q.pop_front()));
          end
          hs_cnt++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_word  = {instr, instr_last, enc_ctrl};
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    time t1, t2;
    int h0;
    logic [4:0]  rt;
    logic [31:0] v;
    int cls;
    total = 0; bad = 0; err_seen = 0; err_exp = 0; hs_cnt = 0;
    rdy_mode = 1; rdy_force = 1'b0;
    reset_n = 1'b0;
    req_valid = 1'b1; req_kind = 1'b0; req_rt = 5'd3; req_value = 32'h1234;
    #1;
    chk("reset_instr_valid", 64'(instr_valid), 64'd0);
    chk("reset_outputs", 64'({instr, instr_last, enc_ctrl, err}), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(posedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("no_capture_in_reset", 64'(instr_valid), 64'd0);
    @(posedge clk);
    #1;

    // Directed vectors with instr_ready held high.
    rdy_force = 1'b1;
    push(32'h34081234, 1'b1, 2'd0); send(0, 5'd8, 32'h00001234, 0, t1); drain(50);
    push(32'h24098000, 1'b1, 2'd1); send(0, 5'd9, 32'hFFFF8000, 0, t1); drain(50);
    push(32'h3C09FFFF, 1'b0, 2'd2); push(32'h35297FFF, 1'b1, 2'd0);
    send(0, 5'd9, 32'hFFFF7FFF, 0, t1); drain(50);
    push(32'h3C011234, 1'b1, 2'd2); send(0, 5'd1, 32'h12340000, 0, t1); drain(50);
    push(32'h34020000, 1'b1, 2'd0); send(0, 5'd2, 32'h00000000, 0, t1); drain(50);
    push(32'h08100006, 1'b1, 2'd3); send(1, 5'd0, 32'h00400018, 0, t1); drain(50);
    send(1, 5'd0, 32'h10000000, 0, t1); drain(50);
    // Illegal jump followed immediately by a legal one during the err cycle.
    send(1, 5'd0, 32'h00400019, 0, t1);
    push(32'h08100006, 1'b1, 2'd3);
    send(1, 5'd4, 32'h00400018, 0, t2);
    chk("accept_in_err_cycle", 64'(t2 - t1), 64'd10);
    drain(50);
    chk("err_pulses_directed", 64'(err_seen), 64'd2);

    // Backpressure: 5 stalled cycles on each of the two words.
    rdy_force = 1'b0;
    @(posedge clk); #1;
    h0 = hs_cnt;
    push(32'h3C09FFFF, 1'b0, 2'd2); push(32'h35297FFF, 1'b1, 2'd0);
    send(0, 5'd9, 32'hFFFF7FFF, 0, t1);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("bp_req_ready_low", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1 rdy_force = 1'b1;
      @(posedge clk); #1 rdy_force = 1'b0;
    end
    @(negedge clk);
    chk("bp_handshakes", 64'(hs_cnt - h0), 64'd2);
    chk("bp_req_ready_back", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Reset while holding the second word.
    send(0, 5'd7, 32'h8765ABCD, 1, t1);
    @(posedge clk); #1 rdy_force = 1'b1;
    @(posedge clk); #1 rdy_force = 1'b0;
    @(negedge clk);
    chk("in_emit2", 64'({instr_valid, instr_last}), 64'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({instr_valid, instr, instr_last, enc_ctrl, err}), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rdy_force = 1'b1;
    push(32'h3C011234, 1'b1, 2'd2); send(0, 5'd1, 32'h12340000, 0, t1); drain(50);

    // Randomized traffic with random backpressure.
    rdy_mode = 0;
    for (int k = 0; k < 150; k++) begin
      cls = $urandom_range(0, 5);
      rt  = 5'($urandom_range(0, 31));
      case (cls)
        0: v = $urandom_range(0, 65535);
        1: v = 32'hFFFF8000 | $urandom_range(0, 32767);
        2: v = $urandom & 32'hFFFF0000;
        3: v = $urandom;
        4: v = $urandom & 32'h0FFFFFFC;
        default: v = $urandom;
      endcase
      send(cls >= 4, rt, v, 1, t1);
    end
    drain(2000);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("err_count", 64'(err_seen), 64'(err_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/li_expander.md
# li_expander

Sequential immediate encoder, the inverse of the datapath's immediate extender. It takes a 32-bit constant (or jump target) plus a destination register and emits the shortest MIPS instruction sequence that rebuilds it: `ori`, `addiu`, `lui`, `lui`+`ori`, or `j`. Each instruction is tagged with the extender control code the datapath will apply to it. It sits in front of the boot/self-test instruction ROM loader and feeds instructions over a valid/ready stream.

## Interface

Parameters: none.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_kind` input 1: 0 = load constant, 1 = jump to target.
- `req_rt` input 5: destination register (load only; ignored for jump).
- `req_value` input 32: constant or byte jump target.
- `instr_valid` output 1: `instr` holds a valid instruction.
- `instr_ready` input 1: downstream accepts `instr`.
- `instr` output 32: encoded instruction word.
- `instr_last` output 1: `instr` is the final word of the current request.
- `enc_ctrl` output 2: extender code for `instr`: 0 zero, 1 sign, 2 upper, 3 jump.
- `err` output 1: one-cycle pulse, request rejected.

## Operation

- FSM states: IDLE, EMIT1, EMIT2. `req_ready` = (state == IDLE).
- Accept: `req_valid && req_ready` on a rising edge. `req_kind`, `req_rt` and `req_value` are registered; the encoding is chosen from the registered copy.
- Load encoding, first match wins (v = value, lo = v[15:0], hi = v[31:16]):
  1. `hi == 0` -> `ori rt,$0,lo` = {6'h0D,5'd0,rt,lo}, enc_ctrl 0, single.
  2. `v[31:15]` all ones -> `addiu rt,$0,lo` = {6'h09,5'd0,rt,lo}, enc_ctrl 1, single.
  3. `lo == 0` -> `lui rt,hi` = {6'h0F,5'd0,rt,hi}, enc_ctrl 2, single.
  4. Otherwise two words:
     - `lui rt,hi`, enc_ctrl 2, `instr_last` 0;
     - then `ori rt,rt,lo` = {6'h0D,rt,rt,lo}, enc_ctrl 0, `instr_last` 1.
- Jump encoding:
  - Legal only if `v[31:28] == 0` and `v[1:0] == 0`, because the extender rebuilds the target as {4'h0,imm26,2'h0}.
  - Legal -> `j` = {6'h02,v[27:2]}, enc_ctrl 3, single.
  - Illegal -> no instruction, `err` pulses high for exactly one cycle, state stays IDLE.
- `rt == 0` is not special: the instruction is emitted as normal.
- Transitions:
  - IDLE -> EMIT1 on accept of a legal request.
  - EMIT1 -> IDLE on output handshake when single.
  - EMIT1 -> EMIT2 on output handshake when two-word.
  - EMIT2 -> IDLE on output handshake.
- Output hold: while `instr_valid && !instr_ready`, `instr`, `instr_last` and `enc_ctrl` stay stable and `instr_valid` stays high.

## Timing

- Reset (reset_n low, asynchronous): state IDLE; `instr_valid`, `instr`, `instr_last`, `enc_ctrl`, `err` are all 0. `req_ready` reads 1 and no request is captured while reset_n is low.
- Reset mid-operation: pending words are discarded. No partial `instr_last` is ever emitted after reset.
- Latency: the first word is valid the cycle after accept. The second word is valid the cycle after the first word's handshake.
- Error timing: `err` is high the cycle after accept. Because the FSM stays in IDLE, a new request may be accepted in that same cycle.
- Throughput:
  - `req_ready` returns high the cycle after the last word's handshake.
  - Minimum spacing is 2 cycles per single-word request and 3 cycles per two-word request.
- No combinational path from `req_*` to `instr*`, or from `instr_ready` to `instr*`.

## Test plan

- Load 0x00001234 to rt=8, instr_ready=1 -> 0x34081234, enc_ctrl 0, last 1, one cycle after accept.
- Load 0xFFFF8000 to rt=9 -> 0x24098000, enc_ctrl 1. Load 0xFFFF7FFF to rt=9 -> two words: 0x3C09FFFF (enc 2, last 0), then 0x35297FFF (enc 0, last 1).
- Load 0x12340000 to rt=1 -> 0x3C011234, enc_ctrl 2, single. Load 0x00000000 to rt=2 -> 0x34020000 (rule 1 wins).
- Jump 0x00400018 -> 0x08100006, enc_ctrl 3. Jump 0x00400019 and jump 0x10000000 -> `err` one-cycle pulse, no `instr_valid`. A back-to-back legal request during the err cycle is accepted.
- Backpressure: two-word load with instr_ready low for 5 cycles on each word -> words stable, exactly two handshakes, `req_ready` low throughout.
- Assert reset_n low while in EMIT2 -> all outputs 0 immediately. After release, a fresh request emits normally.
